// File: rtl/scan_misr_pkg.sv
// Shared definitions for the scan/MISR observation register.
package scan_misr_pkg;

    // Register operating modes as presented on the mode port
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_MISR  = 2'b11
    } mode_e;

    // Compaction run control
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Widest register the signature helper supports
    localparam int unsigned MISR_MAX_W = 64;

    // Galois MISR step: shift left, fold the MSB back through the taps, absorb d.
    // Operates on a wide container; only the low 'width' bits are meaningful.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] q,
        input logic [MISR_MAX_W-1:0] d,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] shifted;
        logic                  msb;
        mask    = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
        msb     = |(q & (MISR_MAX_W'(1) << (width - 1)));
        shifted = (q << 1) & mask;
        if (msb) shifted = shifted ^ poly;
        return (shifted ^ d) & mask;
    endfunction

endpackage

// File: rtl/scan_cell.sv
// One bit of the observation register: mux-D flop selecting hold / load / scan / MISR.
module scan_cell
    import scan_misr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       d,
    input  logic       scan,
    input  logic       misr,
    output logic       q
);

    // Selected next value, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case (sel)
                MODE_HOLD:  q <= q;
                MODE_LOAD:  q <= d;
                MODE_SHIFT: q <= scan;
                default:    q <= misr;
            endcase
        end
    end

endmodule

// File: rtl/scan_misr_pipo.sv
// Parametrised PIPO register with scan shift and MISR compaction, plus the run
// controller that counts compress cycles and grades the final signature.
module scan_misr_pipo
    import scan_misr_pkg::*;
#(
    parameter int unsigned      WIDTH   = 10,
    parameter logic [WIDTH-1:0] POLY    = 10'h009,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int unsigned      NUM_PAT = 16,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             scan_in,
    input  logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] q_out,
    output logic             scan_out,
    output logic             sig_done,
    output logic             sig_pass
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] scan_vec;
    logic [WIDTH-1:0] cell_d;
    logic [1:0]       cell_sel;
    logic             compress;
    logic             last_pat;

    assign nxt      = WIDTH'(misr_next(MISR_MAX_W'(q_out), MISR_MAX_W'(d_in),
                                       MISR_MAX_W'(POLY), WIDTH));
    assign scan_vec = {q_out[WIDTH-2:0], scan_in};
    assign scan_out = q_out[WIDTH-1];
    assign last_pat = (cnt == CNT_W'(NUM_PAT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: start always rearms; the last compress edge closes the run
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RUN;
        else if (mode == MODE_MISR && state == RUN && last_pat)
            state_nxt = DONE;
    end

    // Cell control: start forces a SEED load; compress outside RUN degrades to hold
    always_comb begin
        cell_sel = mode;
        cell_d   = d_in;
        compress = 1'b0;
        if (start) begin
            cell_sel = MODE_LOAD;
            cell_d   = SEED;
        end else if (mode == MODE_MISR) begin
            if (state == RUN) compress = 1'b1;
            else              cell_sel = MODE_HOLD;
        end
    end

    // Pattern counter and sticky result flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            sig_done <= 1'b0;
            sig_pass <= 1'b0;
        end else if (start) begin
            cnt      <= '0;
            sig_done <= 1'b0;
            sig_pass <= 1'b0;
        end else if (compress) begin
            cnt <= cnt + CNT_W'(1);
            if (last_pat) begin
                sig_done <= 1'b1;
                sig_pass <= (nxt == exp_sig);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        scan_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .sel   (cell_sel),
            .d     (cell_d[i]),
            .scan  (scan_vec[i]),
            .misr  (nxt[i]),
            .q     (q_out[i])
        );
    end

endmodule

// File: tb/tb_scan_misr_pipo.sv
// Scoreboard bench for scan_misr_pipo: the driver advances a behavioural model and
// queues the expected post-edge outputs; a monitor pops and compares each cycle.
module tb_scan_misr_pipo;

    localparam int         W    = 10;
    localparam logic [9:0] POLY = 10'h009;
    localparam logic [9:0] SEED = 10'h000;
    localparam int         NP   = 16;

    logic       clk = 1'b0;
    logic       reset, start, scan_in;
    logic [1:0] mode;
    logic [9:0] d_in, exp_sig, q_out;
    logic       scan_out, sig_done, sig_pass;

    always #5 clk = ~clk;

    scan_misr_pipo #(
        .WIDTH   (W),
        .POLY    (POLY),
        .SEED    (SEED),
        .NUM_PAT (NP),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .d_in     (d_in),
        .scan_in  (scan_in),
        .exp_sig  (exp_sig),
        .q_out    (q_out),
        .scan_out (scan_out),
        .sig_done (sig_done),
        .sig_pass (sig_pass)
    );

    typedef struct {
        logic [9:0] q;
        bit         done;
        bit         pass;
        int         cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: register value, compress count, run/done flags
    logic [9:0] m_q;
    int         m_cnt;
    bit         m_run, m_done, m_pass;

    // Multiply by x modulo the feedback polynomial, then add the data word
    function automatic logic [9:0] ref_misr(logic [9:0] q, logic [9:0] d);
        int v;
        v = int'(q) * 2;
        if (v >= 1024) v = (v - 1024) ^ int'(POLY);
        return 10'(v) ^ d;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_cnt = 0; m_run = 0; m_done = 0; m_pass = 0;
    endtask

    // Drive one cycle of stimulus and queue the expected result of its edge
    task automatic cyc(bit st, logic [1:0] md, logic [9:0] d, bit si, logic [9:0] es);
        logic [9:0] n;
        @(negedge clk);
        start = st; mode = md; d_in = d; scan_in = si; exp_sig = es;
        #1;
        check("scan_out", 32'(scan_out), 32'(m_q[9]));
        if (st) begin
            m_q = SEED; m_cnt = 0; m_done = 0; m_pass = 0; m_run = 1;
        end else begin
            case (md)
                2'd1: m_q = d;
                2'd2: m_q = {m_q[8:0], si};
                2'd3: if (m_run) begin
                    n     = ref_misr(m_q, d);
                    m_q   = n;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == NP) begin
                        m_run  = 0;
                        m_done = 1;
                        m_pass = (n == es);
                    end
                end
                default: ;
            endcase
        end
        sbq.push_back('{m_q, m_done, m_pass, m_cnt});
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a queued expectation gets compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("q_out", 32'(q_out), 32'(e.q));
                check("sig_done", 32'(sig_done), 32'(e.done));
                check("sig_pass", 32'(sig_pass), 32'(e.pass));
                check("cnt", 32'(dut.cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; mode = 2'd0; d_in = '0; scan_in = 1'b0; exp_sig = '0;
        model_reset();
        #12;
        check("rst_q", 32'(q_out), 32'h0);
        check("rst_done", 32'(sig_done), 32'h0);
        check("rst_pass", 32'(sig_pass), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Load then hold
        cyc(0, 2'd1, 10'h2A5, 0, '0);
        post(); check("load", 32'(q_out), 32'h2A5);
        repeat (3) cyc(0, 2'd0, 10'h155, 1, '0);
        post(); check("hold", 32'(q_out), 32'h2A5);

        // Scan shift
        cyc(0, 2'd1, 10'h201, 0, '0);
        cyc(0, 2'd2, 10'h000, 1, '0);
        post(); check("shift1", 32'(q_out), 32'h003);
        repeat (10) cyc(0, 2'd2, 10'h3FF, 0, '0);
        post(); check("shift10", 32'(q_out), 32'h000);

        // Single compress with MSB set folds the taps in
        cyc(1, 2'd0, '0, 0, '0);
        cyc(0, 2'd1, 10'h200, 0, '0);
        cyc(0, 2'd3, 10'h000, 0, '0);
        post();
        check("misr1_q", 32'(q_out), 32'h009);
        check("misr1_cnt", 32'(dut.cnt), 32'd1);
        check("misr1_done", 32'(sig_done), 32'd0);

        // Full run, matching signature, then a post-done compress that must hold
        cyc(1, 2'd0, '0, 0, '0);
        repeat (NP) cyc(0, 2'd3, 10'h000, 0, 10'h000);
        post();
        check("run_done", 32'(sig_done), 32'd1);
        check("run_pass", 32'(sig_pass), 32'd1);
        cyc(0, 2'd3, 10'h1FF, 0, 10'h000);
        post(); check("done_hold", 32'(q_out), 32'h000);

        // Full run with a wrong expected signature
        cyc(1, 2'd0, '0, 0, '0);
        repeat (NP - 1) cyc(0, 2'd3, 10'h000, 0, 10'h000);
        cyc(0, 2'd3, 10'h000, 0, 10'h001);
        post();
        check("fail_done", 32'(sig_done), 32'd1);
        check("fail_pass", 32'(sig_pass), 32'd0);

        // Restart mid-run discards progress; restart in DONE rearms
        cyc(1, 2'd0, '0, 0, '0);
        repeat (7) cyc(0, 2'd3, 10'(($urandom % 1023) + 1), 0, '0);
        cyc(1, 2'd3, 10'h3FF, 0, '0);
        post();
        check("restart_q", 32'(q_out), 32'(SEED));
        check("restart_cnt", 32'(dut.cnt), 32'd0);
        repeat (NP - 1) cyc(0, 2'd3, 10'($urandom), 0, '0);
        post(); check("restart_15", 32'(sig_done), 32'd0);
        cyc(0, 2'd3, 10'($urandom), 0, '0);
        post(); check("restart_16", 32'(sig_done), 32'd1);
        cyc(1, 2'd3, 10'h3FF, 0, '0);
        post();
        check("rearm_done", 32'(sig_done), 32'd0);
        check("rearm_cnt", 32'(dut.cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit         st;
            int         r;
            logic [1:0] md;
            logic [9:0] d, es;
            st = ($urandom_range(0, 39) == 0);
            r  = $urandom_range(0, 7);
            md = (r >= 4) ? 2'd3 : 2'(r);
            d  = 10'($urandom);
            es = 10'($urandom);
            if (!st && md == 2'd3 && m_run && m_cnt == NP - 1 && $urandom_range(0, 1) == 1)
                es = ref_misr(m_q, d);
            cyc(st, md, d, 1'($urandom), es);
        end

        // Asynchronous reset mid-clock with a full register and done set
        cyc(1, 2'd0, '0, 0, '0);
        repeat (NP) cyc(0, 2'd3, 10'($urandom), 0, '0);
        cyc(0, 2'd1, 10'h3FF, 0, '0);
        post();
        check("pre_rst_q", 32'(q_out), 32'h3FF);
        check("pre_rst_done", 32'(sig_done), 32'd1);
        start = 1'b0; mode = 2'd0;
        reset = 1'b0;
        #1;
        check("async_q", 32'(q_out), 32'h0);
        check("async_done", 32'(sig_done), 32'd0);
        check("async_pass", 32'(sig_pass), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 2'd3, 10'h155, 0, '0);
        post(); check("idle_nomisr", 32'(q_out), 32'h0);

        repeat (2) post();
        check("drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
